// File: rtl/div_unit.sv
// rtl/div_unit.sv - RV32M iterative divider: 32-cycle restoring radix-2 with divide-by-zero and overflow fast paths.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [4:0]       select,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic [WIDTH-1:0] result,
   output logic             valid,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t state, next_state;

   logic [4:0]       count;
   logic             op_rem;
   logic             quo_neg;
   logic             rem_neg;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;

   logic             sel_ok;
   logic             sel_signed;
   logic             sign1;
   logic             sign2;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic             div_zero;
   logic             overflow;
   logic             fast;
   logic             accept;
   logic             last_iter;
   logic [WIDTH-1:0] fast_result;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   always_comb begin
      sel_ok      = start && (select[4:2] == 3'b011);
      sel_signed  = !select[1];
      sign1       = sel_signed && data1[WIDTH-1];
      sign2       = sel_signed && data2[WIDTH-1];
      mag1        = sign1 ? -data1 : data1;
      mag2        = sign2 ? -data2 : data2;
      div_zero    = (data2 == '0);
      overflow    = sel_signed && (data1 == {1'b1, {(WIDTH-1){1'b0}}}) && (data2 == '1);
      fast        = div_zero || overflow;
      accept      = (state == S_IDLE) && sel_ok;
      last_iter   = (state == S_CALC) && (count == 5'd31);
      fast_result = '0;
      if (div_zero) begin
         fast_result = select[0] ? data1 : '1;
      end else if (!select[0]) begin
         fast_result = {1'b1, {(WIDTH-1){1'b0}}};
      end

      // rem can reach 2*divisor-1 after the shift, so compare on WIDTH+1 bits
      rem_sh   = {rem_q, quo_q[WIDTH-1]};
      diff     = rem_sh - {1'b0, divisor_q};
      ge       = (rem_sh >= {1'b0, divisor_q});
      rem_next = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], ge};
      quo_fix  = quo_neg ? -quo_next : quo_next;
      rem_fix  = rem_neg ? -rem_next : rem_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (sel_ok) next_state = fast ? S_DONE : S_CALC;
         S_CALC: if (count == 5'd31) next_state = S_DONE;
         S_DONE: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (flush) begin
         next_state = S_IDLE;
      end
   end

   assign busy  = (state != S_IDLE);
   assign valid = (state == S_DONE);

   // RESULT is loaded on the edge entering DONE so it is already stable while VALID is high
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         op_rem    <= 1'b0;
         quo_neg   <= 1'b0;
         rem_neg   <= 1'b0;
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         result    <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (accept) begin
         count     <= '0;
         op_rem    <= select[0];
         quo_neg   <= sign1 ^ sign2;
         rem_neg   <= sign1;
         divisor_q <= mag2;
         rem_q     <= '0;
         quo_q     <= mag1;
         if (fast) begin
            result <= fast_result;
         end
      end else if (state == S_CALC) begin
         rem_q <= rem_next;
         quo_q <= quo_next;
         count <= count + 5'd1;
         if (last_iter) begin
            result <= op_rem ? rem_fix : quo_fix;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit: latency, signed/unsigned results, fast paths, flush and reset.
module tb_div_unit;

   localparam logic [4:0] OP_DIV  = 5'b01100;
   localparam logic [4:0] OP_REM  = 5'b01101;
   localparam logic [4:0] OP_DIVU = 5'b01110;
   localparam logic [4:0] OP_REMU = 5'b01111;

   logic        clk;
   logic        reset;
   logic        start;
   logic        flush;
   logic [4:0]  select;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [31:0] result;
   logic        valid;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .select (select),
      .data1  (data1),
      .data2  (data2),
      .result (result),
      .valid  (valid),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      logic [31:0] e;
      string       nm;
      if (valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: result=%h, no result expected", result);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (result !== e) begin
               n_fail++;
               $display("FAIL %s: result=%h, required %h", nm, result, e);
            end
         end
      end
   end

   function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'h0) return sel[0] ? a : 32'hFFFFFFFF;
      if (!sel[1] && a == 32'h80000000 && b == 32'hFFFFFFFF) return sel[0] ? 32'h0 : 32'h80000000;
      case (sel)
         OP_DIV:  return $signed(a) / $signed(b);
         OP_REM:  return $signed(a) % $signed(b);
         OP_DIVU: return a / b;
         default: return a % b;
      endcase
   endfunction

   // Called between edges with the DUT idle; START is sampled on the next rising edge.
   task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
      int lat;
      bit busy_bad;
      start  = 1'b1;
      select = sel;
      data1  = a;
      data2  = b;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      start  = 1'b0;
      data1  = $urandom;
      data2  = $urandom;
      select = 5'($urandom);
      lat = 0;
      busy_bad = 0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge clk);
         if (c <= exp_lat && busy !== 1'b1) busy_bad = 1;
         if (valid === 1'b1) lat = c;
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s_latency: valid in cycle %0d, required %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (busy_bad) begin
         n_fail++;
         $display("FAIL %s_busy: busy low during op, required high cycles 1-%0d", name, exp_lat);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle_after: busy=%b valid=%b, required 0 0", name, busy, valid);
      end
      n_checks++;
      if (result !== exp) begin
         n_fail++;
         $display("FAIL %s_hold: result=%h, required %h", name, result, exp);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      select = OP_DIV;
      data1 = 32'd0;
      data2 = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (result !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: result=%h valid=%b busy=%b, required 0 0 0", result, valid, busy);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_spec_vectors;
      run_op(OP_DIV,  32'd100,      32'd7,        32'd14,       33, "div_100_7");
      run_op(OP_REM,  32'd100,      32'd7,        32'd2,        33, "rem_100_7");
      run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2");
      run_op(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");
      run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, "divu_m7_2");
      run_op(OP_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, "div_100_m7");
      run_op(OP_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33, "rem_m100_7");
      run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "divu_max_1");
      run_op(OP_REMU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        33, "remu_max_max");
   endtask

   task automatic test_fast_paths;
      run_op(OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_by0");
      run_op(OP_REMU, 32'd5,        32'd0,        32'd5,        1, "remu_by0");
      run_op(OP_DIV,  32'd7,        32'd0,        32'hFFFFFFFF, 1, "div_by0");
      run_op(OP_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, "rem_by0");
      run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
      run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1, "rem_ovf");
   endtask

   task automatic test_random;
      logic [4:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 8; i++) begin
         sel = {3'b011, 2'($urandom_range(0, 3))};
         a = $urandom;
         if (a == 32'h80000000) a = 32'd1;
         b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
         if ($urandom_range(0, 1) == 1) b = -b;
         if (b == 32'h0) b = 32'd3;
         run_op(sel, a, b, model(sel, a, b), 33, $sformatf("random_%0d", i));
      end
   endtask

   task automatic test_ignored_start;
      start = 1'b1;
      select = 5'b00000;
      data1 = 32'd10;
      data2 = 32'd2;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_select_00000: busy=%b, required 0", busy);
      end
      select = 5'b10000;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_select_10000: busy=%b, required 0", busy);
      end
      select = OP_DIV;
      flush = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_beats_start: busy=%b, required 0", busy);
      end
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_flush;
      run_op(OP_DIVU, 32'd50, 32'd5, 32'd10, 33, "pre_flush");
      start = 1'b1;
      select = OP_DIV;
      data1 = 32'd1000;
      data2 = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_abort: busy=%b valid=%b, required 0 0", busy, valid);
      end
      n_checks++;
      if (result !== 32'd10) begin
         n_fail++;
         $display("FAIL flush_result_kept: result=%h, required %h", result, 32'd10);
      end
      run_op(OP_DIV, 32'd1000, 32'd3, 32'd333, 33, "after_flush");
   endtask

   task automatic test_back_to_back;
      logic [31:0] v[4];
      for (int k = 0; k < 4; k++) v[k] = $urandom;
      start = 1'b1;
      select = OP_DIVU;
      data2 = 32'd13;
      for (int k = 0; k < 3; k++) begin
         data1 = v[k];
         exp_q.push_back(v[k] / 32'd13);
         name_q.push_back($sformatf("b2b_%0d", k));
         @(posedge clk);
         for (int i = 0; i < 33; i++) begin
            #1;
            data1 = $urandom;
            @(posedge clk);
         end
         #1;
      end
      data1 = v[3];
      @(posedge clk);
      for (int i = 0; i < 19; i++) begin
         #1;
         data1 = $urandom;
         @(posedge clk);
      end
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (result !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_calc: result=%h valid=%b busy=%b, required 0 0 0", result, valid, busy);
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_spec_vectors();
      test_fast_paths();
      test_random();
      test_ignored_start();
      test_flush();
      test_back_to_back();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; only 32 is supported.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 START  input  1  request to begin an operation; sampled only in state IDLE.
REQ-005 FLUSH  input  1  pipeline flush; aborts any operation in progress.
REQ-006 SELECT  input  5  operation code: 5'b01100 DIV, 5'b01101 REM, 5'b01110 DIVU, 5'b01111 REMU.
REQ-007 DATA1  input  32  dividend; captured when START is accepted.
REQ-008 DATA2  input  32  divisor; captured when START is accepted.
REQ-009 RESULT  output  32  quotient or remainder; held stable from VALID until the next accepted START.
REQ-010 VALID  output  1  one-cycle pulse marking RESULT as new.
REQ-011 BUSY  output  1  high while an operation is in flight; EX-stage stall request to the hazard unit.

Function
REQ-012 Three states SHALL be used: IDLE, CALC, DONE; BUSY SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-013 A START is accepted only in IDLE with SELECT in {01100..01111}; START with any other SELECT, or START in CALC/DONE, SHALL be ignored.
REQ-014 On acceptance, the unit SHALL latch SELECT, |DATA1|, |DATA2| (magnitudes for signed ops, raw for unsigned ops), the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
REQ-015 Normal path: IDLE -> CALC; CALC runs exactly 32 restoring radix-2 iterations, one per cycle, driven by a 5-bit counter; after the 32nd iteration -> DONE.
REQ-016 Each iteration: shift {rem,quo} left 1 bit; if rem >= divisor then subtract divisor from rem and set quo[0]=1.
REQ-017 In DONE the unit SHALL apply sign fix-up (two's-complement negate quo/rem per the latched signs, signed ops only), load RESULT, assert VALID for one cycle, then return to IDLE.
REQ-018 Latency: START accepted at edge 0 -> VALID high in cycle 33 on the normal path; a back-to-back START is accepted no earlier than cycle 34.
REQ-019 Fast path, divisor == 0: IDLE -> DONE directly; DIV/DIVU result 32'hFFFFFFFF, REM/REMU result DATA1; VALID in cycle 1.
REQ-020 Fast path, signed overflow (DIV/REM, DATA1 = 32'h80000000, DATA2 = 32'hFFFFFFFF): IDLE -> DONE; DIV result 32'h80000000, REM result 0; VALID in cycle 1.
REQ-021 FLUSH high at any edge SHALL force state IDLE, clear the counter and suppress VALID in that cycle; RESULT is left unchanged.
REQ-022 When FLUSH and START are both high in IDLE, FLUSH SHALL win and no operation starts.
REQ-023 DATA1, DATA2 and SELECT changes after acceptance SHALL NOT affect the operation in flight.
REQ-024 Quotient rounding SHALL be toward zero; the remainder sign SHALL equal the dividend sign (RV32M semantics).

Reset
REQ-025 With RESET high at an edge: state=IDLE, counter=0, RESULT=32'h0, VALID=0, BUSY=0, all internal registers 0.
REQ-026 RESET asserted mid-CALC or in DONE SHALL abort the operation with no VALID pulse; RESET has priority over FLUSH and START.

Verification
REQ-027 DIV with DATA1=100, DATA2=7 -> BUSY high in cycles 1-33, VALID in cycle 33, RESULT=14; REM on the same operands -> 2.
REQ-028 DIV with DATA1=-7 (32'hFFFFFFF9), DATA2=2 -> RESULT=32'hFFFFFFFD (-3); REM -> 32'hFFFFFFFF (-1); DIVU on the same operands -> 32'h7FFFFFFC.
REQ-029 DIVU with DATA2=0, DATA1=5 -> VALID in cycle 1, RESULT=32'hFFFFFFFF; REMU -> 5.
REQ-030 DIV with DATA1=32'h80000000, DATA2=32'hFFFFFFFF -> VALID in cycle 1, RESULT=32'h80000000; REM -> 0.
REQ-031 START a DIV, assert FLUSH in cycle 10 -> BUSY=0 in cycle 11, no VALID, RESULT keeps its previous value; a new START in cycle 11 completes normally.
REQ-032 START held high continuously with changing DATA1 -> exactly one operation per 34 cycles, each RESULT matching the operands present at its acceptance edge; RESET in cycle 20 -> all outputs 0 at the next edge.
